// File: rtl/spi_upcounter_slave_rx.sv
// SPI mode-0 slave receiver for the up-counter display link.
// Oversamples SCLK/MOSI/CS_N in the clk domain and assembles 16-bit frames
// of {run, clear, count[13:0]}. Frames whose count is legal are presented
// as registered count/run flags with one-cycle valid and clear strobes.
// Aborted or out-of-range frames raise a one-cycle error strobe.
module spi_upcounter_slave_rx #(
   parameter int DATA_WIDTH  = 16,
   parameter int CNT_WIDTH   = 14,
   parameter int COUNT_MAX   = 9999,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sclk,
   input  logic                 mosi,
   input  logic                 cs_n,
   output logic [CNT_WIDTH-1:0] o_count,
   output logic                 o_runstop,
   output logic                 o_clear,
   output logic                 o_valid,
   output logic                 o_frame_err
);

   localparam int                   BCW          = $clog2(DATA_WIDTH);
   localparam logic [BCW-1:0]       LP_LAST_BIT  = BCW'(DATA_WIDTH - 1);
   localparam logic [BCW-1:0]       LP_ONE       = BCW'(1);
   localparam logic [BCW-1:0]       LP_ZERO      = BCW'(0);
   localparam logic [CNT_WIDTH-1:0] LP_COUNT_MAX = CNT_WIDTH'(COUNT_MAX);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RECEIVE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic                   r_sclk_d;
   logic                   r_cs_d;

   logic [DATA_WIDTH-1:0]  r_shift;
   logic [BCW-1:0]         r_bit_cnt;

   logic [CNT_WIDTH-1:0]   r_count;
   logic                   r_runstop;
   logic                   r_clear;
   logic                   r_valid;
   logic                   r_frame_err;

   logic [CNT_WIDTH-1:0]   w_count_nxt;
   logic                   w_runstop_nxt;
   logic                   w_clear_nxt;
   logic                   w_valid_nxt;
   logic                   w_frame_err_nxt;

   logic                   w_sclk;
   logic                   w_mosi;
   logic                   w_cs;
   logic                   w_sclk_rise;
   logic                   w_cs_fall;
   logic [CNT_WIDTH-1:0]   w_frame_cnt;

   assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
   assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
   assign w_cs        = r_cs_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk & ~r_sclk_d;
   assign w_cs_fall   = ~w_cs & r_cs_d;
   assign w_frame_cnt = r_shift[CNT_WIDTH-1:0];

   // Input synchronizers plus one delay flop per edge-detected signal; idle levels on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sclk_sync <= {SYNC_STAGES{1'b0}};
         r_mosi_sync <= {SYNC_STAGES{1'b0}};
         r_cs_sync   <= {SYNC_STAGES{1'b1}};
         r_sclk_d    <= 1'b0;
         r_cs_d      <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
         r_sclk_d    <= w_sclk;
         r_cs_d      <= w_cs;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state: chip select high always wins over a coincident SCLK edge.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_cs_fall || !w_cs) begin
               w_state_nxt = S_RECEIVE;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RECEIVE: begin
            if (w_cs) begin
               w_state_nxt = S_IDLE;
            end else if (w_sclk_rise && (r_bit_cnt == LP_LAST_BIT)) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_RECEIVE;
            end
         end
         S_DONE: begin
            if (!w_cs) begin
               w_state_nxt = S_RECEIVE;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Shift register and bit counter; bits are only taken while receiving with CS_N low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift   <= {DATA_WIDTH{1'b0}};
         r_bit_cnt <= LP_ZERO;
      end else begin
         case (r_state)
            S_RECEIVE: begin
               if (w_cs) begin
                  r_bit_cnt <= LP_ZERO;
               end else if (w_sclk_rise) begin
                  r_shift <= {r_shift[DATA_WIDTH-2:0], w_mosi};
                  if (r_bit_cnt == LP_LAST_BIT) begin
                     r_bit_cnt <= LP_ZERO;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + LP_ONE;
                  end
               end else begin
                  r_bit_cnt <= r_bit_cnt;
               end
            end
            default: begin
               r_bit_cnt <= LP_ZERO;
            end
         endcase
      end
   end

   // FSM output decode: next values of the registered outputs.
   // A CS_N release with no bits collected is the normal end of a frame that
   // already completed, so only a partially received frame counts as an abort.
   always_comb begin
      w_count_nxt     = r_count;
      w_runstop_nxt   = r_runstop;
      w_clear_nxt     = 1'b0;
      w_valid_nxt     = 1'b0;
      w_frame_err_nxt = 1'b0;
      case (r_state)
         S_RECEIVE: begin
            if (w_cs && (r_bit_cnt != LP_ZERO)) begin
               w_frame_err_nxt = 1'b1;
            end else begin
               w_frame_err_nxt = 1'b0;
            end
         end
         S_DONE: begin
            if (w_frame_cnt <= LP_COUNT_MAX) begin
               w_count_nxt   = w_frame_cnt;
               w_runstop_nxt = r_shift[DATA_WIDTH-1];
               w_clear_nxt   = r_shift[DATA_WIDTH-2];
               w_valid_nxt   = 1'b1;
            end else begin
               w_frame_err_nxt = 1'b1;
            end
         end
         default: begin
            w_frame_err_nxt = 1'b0;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count     <= {CNT_WIDTH{1'b0}};
         r_runstop   <= 1'b0;
         r_clear     <= 1'b0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_count     <= w_count_nxt;
         r_runstop   <= w_runstop_nxt;
         r_clear     <= w_clear_nxt;
         r_valid     <= w_valid_nxt;
         r_frame_err <= w_frame_err_nxt;
      end
   end

   assign o_count     = r_count;
   assign o_runstop   = r_runstop;
   assign o_clear     = r_clear;
   assign o_valid     = r_valid;
   assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_upcounter_slave_rx.sv
// Self-checking bench for spi_upcounter_slave_rx: directed and random SPI frames
// at clk/10 SCLK, checked against a frame-level reference model and scoreboard.
module tb_spi_upcounter_slave_rx;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        sclk = 1'b0;
   logic        mosi = 1'b0;
   logic        cs_n = 1'b1;
   logic [13:0] o_count;
   logic        o_runstop;
   logic        o_clear;
   logic        o_valid;
   logic        o_frame_err;

   int tests = 0;
   int fails = 0;

   // monitor state
   int          valid_cnt = 0;
   int          err_cnt = 0;
   int          long_pulse = 0;
   int          orphan_clear = 0;
   logic        prev_valid = 1'b0;
   logic        prev_err = 1'b0;
   logic [15:0] got_q[$];

   // reference model state
   int          exp_count = 0;
   int          exp_run = 0;
   logic [15:0] exp_q[$];

   spi_upcounter_slave_rx dut (
      .clk         (clk),
      .reset       (reset),
      .sclk        (sclk),
      .mosi        (mosi),
      .cs_n        (cs_n),
      .o_count     (o_count),
      .o_runstop   (o_runstop),
      .o_clear     (o_clear),
      .o_valid     (o_valid),
      .o_frame_err (o_frame_err)
   );

   always #5 clk = ~clk;

   // Pulse monitor, sampled on the falling clock edge.
   always @(negedge clk) begin
      if (reset) begin
         if (o_valid) begin
            valid_cnt++;
            got_q.push_back({o_runstop, o_clear, o_count});
         end
         if (o_frame_err) err_cnt++;
         if ((o_valid && prev_valid) || (o_frame_err && prev_err)) long_pulse++;
         if (o_clear && !o_valid) orphan_clear++;
         prev_valid = o_valid;
         prev_err   = o_frame_err;
      end else begin
         prev_valid = 1'b0;
         prev_err   = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Shift n bits of f, MSB first, mode 0 with 50-unit half periods.
   task automatic send_bits(input logic [15:0] f, input int n);
      for (int i = 15; i > 15 - n; i--) begin
         mosi = f[i];
         #50;
         sclk = 1'b1;
         #50;
         sclk = 1'b0;
      end
   endtask

   // Send n (1 or 2) frames under one CS_N low period and score them.
   task automatic run_frames(input logic [15:0] fa, input logic [15:0] fb, input int n);
      logic [15:0] fl[2];
      logic [15:0] got;
      logic [15:0] want;
      int v0, e0, ev, ee, c;
      fl[0] = fa;
      fl[1] = fb;
      v0 = valid_cnt;
      e0 = err_cnt;
      ev = 0;
      ee = 0;
      cs_n = 1'b0;
      #100;
      for (int k = 0; k < n; k++) begin
         send_bits(fl[k], 16);
         c = int'(fl[k]) % 16384;
         if (c <= 9999) begin
            exp_count = c;
            exp_run   = int'(fl[k]) / 32768;
            exp_q.push_back(16'(exp_run * 32768 + ((int'(fl[k]) / 16384) % 2) * 16384 + c));
            ev++;
         end else begin
            ee++;
         end
      end
      #50;
      cs_n = 1'b1;
      #200;
      chk("valid_pulses", valid_cnt - v0, ev);
      chk("err_pulses", err_cnt - e0, ee);
      while (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         if (got_q.size() > 0) got = got_q.pop_front();
         else got = 16'hxxxx;
         chk("frame_fields", got, want);
      end
      got_q.delete();
      chk("count_hold", o_count, exp_count);
      chk("runstop_hold", o_runstop, exp_run);
   endtask

   initial begin
      int e0, v0;
      logic [15:0] f;

      // Reset held with toggling SPI lines
      for (int i = 0; i < 6; i++) begin
         sclk = ~sclk;
         mosi = 1'($urandom);
         #20;
         chk("reset_outputs", {o_count, o_runstop, o_clear, o_valid, o_frame_err}, 0);
      end
      sclk = 1'b0;
      mosi = 1'b0;
      #20;
      reset = 1'b1;
      #100;
      chk("post_reset_outputs", {o_count, o_runstop, o_clear, o_valid, o_frame_err}, 0);

      // Single frame: run=1, count=3000
      run_frames(16'h8BB8, 16'h0000, 1);

      // Back-to-back frames under one CS_N low
      run_frames(16'h4000, 16'h0005, 2);

      // Accepted 42, then out-of-range 10000
      run_frames(16'h002A, 16'h0000, 1);
      run_frames(16'h2710, 16'h0000, 1);
      chk("oor_count_kept", o_count, 42);

      // Abort after 9 bits, then a clean frame
      v0 = valid_cnt;
      e0 = err_cnt;
      cs_n = 1'b0;
      #100;
      send_bits(16'h8001, 9);
      #50;
      cs_n = 1'b1;
      #200;
      chk("abort_err", err_cnt - e0, 1);
      chk("abort_no_valid", valid_cnt - v0, 0);
      chk("abort_count_kept", o_count, 42);
      run_frames(16'h0007, 16'h0000, 1);

      // Reset mid-frame after 8 bits
      cs_n = 1'b0;
      #100;
      send_bits(16'hFFFF, 8);
      reset = 1'b0;
      #30;
      chk("midframe_reset_outputs", {o_count, o_runstop, o_clear, o_valid, o_frame_err}, 0);
      cs_n = 1'b1;
      mosi = 1'b0;
      #50;
      reset = 1'b1;
      exp_count = 0;
      exp_run = 0;
      got_q.delete();
      #100;
      chk("after_reset_outputs", {o_count, o_runstop, o_clear, o_valid, o_frame_err}, 0);
      run_frames(16'h8064, 16'h0000, 1);

      // Random frames, roughly half forced in range
      for (int r = 0; r < 10; r++) begin
         f = 16'($urandom);
         if ($urandom_range(0, 1) == 1) f[13:0] = 14'($urandom_range(0, 9999));
         if (r % 3 == 0) run_frames(f, 16'($urandom), 2);
         else run_frames(f, 16'h0000, 1);
      end

      // Boundary counts 9999 / 10000
      run_frames(16'h270F, 16'h2710, 2);

      chk("pulse_width", long_pulse, 0);
      chk("clear_without_valid", orphan_clear, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/spi_upcounter_slave_rx.md
Name: spi_upcounter_slave_rx

Overview:
- SPI slave receiver at the display end of the up-counter link. Recovers 16-bit frames from the SPI master: run/clear flags plus a 14-bit counter value.
- Oversamples SCLK/MOSI/CS_N in the system clock domain, assembles frames and validates the count.
- Presents registered count/flags with a one-cycle valid strobe to the FND display logic.

Parameters:
- DATA_WIDTH, 16, frame length in bits (MSB first).
- CNT_WIDTH, 14, counter field width, frame bits [CNT_WIDTH-1:0].
- COUNT_MAX, 9999, largest legal counter value.
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x SCLK frequency.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- sclk  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0).
- mosi  input  1  SPI data from master.
- cs_n  input  1  SPI chip select, active-low.
- o_count  output  CNT_WIDTH  last accepted counter value.
- o_runstop  output  1  last accepted run flag (frame bit 15), level.
- o_clear  output  1  one-cycle pulse when an accepted frame has bit 14 = 1.
- o_valid  output  1  one-cycle pulse: a frame was accepted and outputs were updated.
- o_frame_err  output  1  one-cycle pulse: frame aborted or count out of range.

Behaviour:
- Reset (reset=0, async):
  - All outputs 0, state IDLE, bit counter 0, shift register 0.
  - Synchronizer flops preset to sclk=0, mosi=0, cs_n=1.
- Synchronization: sclk, mosi and cs_n each pass through SYNC_STAGES flops.
  - Edges are detected from the last stage against one extra delay flop.
  - sclk_rise = sync high and previous low; cs_fall and cs_rise are defined the same way.
- State IDLE:
  - Bit counter held at 0.
  - cs_fall or synced cs_n=0 -> RECEIVE.
- State RECEIVE:
  - On each sclk_rise, shift synced mosi into the LSB of the shift register and increment the bit counter.
  - If sclk_rise occurs with bit counter = DATA_WIDTH-1 -> DONE next cycle, with the full frame in the shift register.
  - If cs_rise occurs before the last bit -> o_frame_err pulse, bit counter cleared, -> IDLE. Outputs unchanged.
  - Same-cycle sclk_rise and cs_rise: cs_rise wins; the bit is discarded.
- State DONE (exactly one cycle):
  - If frame[13:0] <= COUNT_MAX: o_count <= frame[13:0], o_runstop <= frame[15], o_clear <= frame[14] (pulse), o_valid <= 1 (pulse).
  - If frame[13:0] > COUNT_MAX: o_frame_err pulse; o_count, o_runstop, o_valid and o_clear unchanged/0.
  - Bit counter cleared.
  - Next state: RECEIVE if synced cs_n=0 (back-to-back frames without CS_N release), else IDLE.
- Latency: o_valid/o_clear/o_frame_err assert 1 clk after the cycle in which the final sclk_rise is detected.
  - Total from the external 16th SCLK rising edge is SYNC_STAGES+2 clk.
- Extra SCLK edges after a frame with CS_N still low start the next frame; bits are never lost across a DONE cycle. A DONE cycle cannot coincide with an sclk_rise given the 8x ratio.
- sclk_rise while cs_n is synced high is ignored.
- o_count and o_runstop hold their values indefinitely between accepted frames.
- Pulse outputs are never asserted for more than one consecutive cycle per frame.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is discarded.

Test Plan:
- Reset: hold reset=0 with toggling sclk/mosi -> all outputs 0; release -> state IDLE, outputs remain 0.
- Single frame 16'h8BB8 (run=1, clr=0, count=3000) at clk/10 SCLK -> one o_valid pulse, o_count=3000, o_runstop=1, o_clear=0, o_frame_err=0.
- Back-to-back frames 16'h4000 then 16'h0005 under one CS_N low -> two o_valid pulses; first with o_clear pulse and count 0, second with count 5, o_runstop=0.
- Out-of-range frame 16'h2710 (count=10000) after an accepted count 42 -> o_frame_err pulse, no o_valid, o_count stays 42.
- Abort: raise cs_n after 9 bits of 16'h8001 -> o_frame_err pulse. A following full frame 16'h0007 is received correctly (o_count=7), proving the bit counter resynchronized.
- Reset mid-frame after 8 bits, then a clean frame 16'h8064 -> outputs 0 during reset, then o_count=100, o_runstop=1 with one o_valid pulse.
